// File: rtl/mmio_pkg.sv
// ---------------------------------------------------------------------------
// mmio_pkg -- shared constants and types for the MMIO FIFO port.
//
// Holds the register offsets relative to BASE, the STATUS bit positions
// (also consumed by firmware tests), the register-select enum, the packed
// STATUS layout and the address decode helper.
// ---------------------------------------------------------------------------
package mmio_pkg;

  // Register offsets from BASE.
  localparam logic [31:0] DATA_OFS   = 32'h0;
  localparam logic [31:0] STATUS_OFS = 32'h4;

  // STATUS bit positions.
  localparam int ST_RX_NOT_EMPTY = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_TX_OVF       = 2;
  localparam int ST_RX_UNF       = 3;
  localparam int ST_RX_CNT_LSB   = 4;
  localparam int ST_TX_CNT_LSB   = 8;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_DATA,
    REG_STATUS
  } reg_sel_e;

  // Field order matches the bit positions above, MSB first.
  typedef struct packed {
    logic [19:0] rsvd;
    logic [3:0]  tx_cnt;
    logic [3:0]  rx_cnt;
    logic        rx_unf;
    logic        tx_ovf;
    logic        tx_full;
    logic        rx_not_empty;
  } status_t;

  function automatic reg_sel_e decode_reg(input logic [31:0] addr,
                                          input logic [31:0] base);
    if (addr == base + DATA_OFS)        return REG_DATA;
    else if (addr == base + STATUS_OFS) return REG_STATUS;
    else                                return REG_NONE;
  endfunction

endpackage

// File: rtl/mmio_fifo_port_if.sv
// ---------------------------------------------------------------------------
// mmio_fifo_port_if -- bundle of the CPU bus and the two byte streams that
// surround mmio_fifo_port.
//
//   CPU bus : addr, we, re, wdata -> port ; rdata, sel <- port
//   TX      : out_data, out_valid -> sink ; out_ready <- sink
//   RX      : in_data, in_valid -> port   ; in_ready <- port
//
// master : the environment (CPU plus external stream endpoints)
// slave  : the FIFO port itself
// ---------------------------------------------------------------------------
interface mmio_fifo_port_if;
  logic [31:0] addr;
  logic        we;
  logic        re;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;

  modport master (
    output addr, we, re, wdata, out_ready, in_data, in_valid,
    input  rdata, sel, out_data, out_valid, in_ready
  );

  modport slave (
    input  addr, we, re, wdata, out_ready, in_data, in_valid,
    output rdata, sel, out_data, out_valid, in_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo -- single-clock FIFO, DEPTH entries of WIDTH bits.
//
//   clk, reset : clock, asynchronous active-high reset (empties the FIFO)
//   push, din  : write request and data; accepted when not full, or when full
//                together with an effective pop in the same cycle
//   pop        : read request; ignored when empty
//   dout       : head entry (meaningless while empty)
//   full/empty : occupancy flags from registered state
//   count      : occupancy, 0..DEPTH
//
// DEPTH must be a power of two (>=2) so the pointers wrap by overflow.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q,  count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    do_pop   = pop & ~empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = din;
  end

  // NOTE: state flops use non-blocking assignments only; the blocking
  // assignments above are combinational and never describe storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by the
  // pointers and count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mmio_fifo_port.sv
// ---------------------------------------------------------------------------
// mmio_fifo_port -- memory-mapped byte port with a TX and an RX FIFO.
//
//   clk, reset          : clock, asynchronous active-high reset
//   addr, we, re, wdata : CPU byte address, store/load strobes, store data
//   rdata, sel          : combinational load data and read-mux steer
//   out_data/valid/ready: TX byte stream (CPU -> external)
//   in_data/valid/ready : RX byte stream (external -> CPU)
//
// Registers:
//   BASE+0 DATA   : store pushes wdata[7:0] to TX; load returns RX head and
//                   pops it (returns 0 and sets RX_UNF when RX is empty)
//   BASE+4 STATUS : {TX count[11:8], RX count[7:4], RX_UNF, TX_OVF,
//                   TX_FULL, RX_NOT_EMPTY}; store is write-1-to-clear for
//                   TX_OVF (bit2) and RX_UNF (bit3)
// A store wins over a load in the same cycle.
// ---------------------------------------------------------------------------
module mmio_fifo_port
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'h800,
  parameter int          DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        sel,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  reg_sel_e    reg_sel;
  logic        data_wr, data_rd, status_wr;
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  tx_dout, rx_dout;
  logic [CW-1:0] tx_count, rx_count;
  logic        tx_ovf_q, tx_ovf_d;
  logic        rx_unf_q, rx_unf_d;
  status_t     status;
  logic        unused_wdata;

  // Only the low byte and the two clear bits of a store are meaningful.
  assign unused_wdata = ^wdata[31:8];

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (wdata[7:0]),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (in_data),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // Bus decode and FIFO control.
  always_comb begin
    reg_sel   = decode_reg(addr, BASE);
    data_wr   = we & (reg_sel == REG_DATA);
    data_rd   = re & ~we & (reg_sel == REG_DATA);
    status_wr = we & (reg_sel == REG_STATUS);

    tx_pop    = ~tx_empty & out_ready;
    // Accepting into a full TX relies on the head draining this same edge.
    tx_push   = data_wr & (~tx_full | tx_pop);
    rx_pop    = data_rd & ~rx_empty;
    // in_ready comes from registered occupancy only; a CPU pop in this
    // cycle does not open a slot until the next one.
    rx_push   = in_valid & ~rx_full;

    tx_ovf_d = tx_ovf_q;
    if (status_wr && wdata[ST_TX_OVF])   tx_ovf_d = 1'b0;
    if (data_wr && tx_full && !tx_pop)   tx_ovf_d = 1'b1;

    rx_unf_d = rx_unf_q;
    if (status_wr && wdata[ST_RX_UNF])   rx_unf_d = 1'b0;
    if (data_rd && rx_empty)             rx_unf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_unf_q <= rx_unf_d;
    end
  end

  // Outputs.
  always_comb begin
    status              = '0;
    status.rx_not_empty = ~rx_empty;
    status.tx_full      = tx_full;
    status.tx_ovf       = tx_ovf_q;
    status.rx_unf       = rx_unf_q;
    status.rx_cnt       = 4'(rx_count);
    status.tx_cnt       = 4'(tx_count);

    sel   = (reg_sel != REG_NONE);
    rdata = '0;
    unique case (reg_sel)
      // RX storage is stale while empty, so the head is masked to zero.
      REG_DATA:   rdata = rx_empty ? 32'h0 : {24'h0, rx_dout};
      REG_STATUS: rdata = status;
      default:    rdata = '0;
    endcase

    out_valid = ~tx_empty;
    out_data  = tx_dout;
    in_ready  = ~rx_full;
  end

endmodule

// File: tb/tb_mmio_fifo_port.sv
// ---------------------------------------------------------------------------
// tb_mmio_fifo_port -- directed and randomized bench for mmio_fifo_port.
// A queue-based model of both FIFOs and the two sticky flags supplies every
// expected value; directed steps also compare against fixed constants.
// ---------------------------------------------------------------------------
module tb_mmio_fifo_port;

  localparam logic [31:0] BASE  = 32'h800;
  localparam int          DEPTH = 4;

  logic clk;
  logic reset;

  mmio_fifo_port_if bus ();

  mmio_fifo_port #(.BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (bus.addr),
    .we        (bus.we),
    .re        (bus.re),
    .wdata     (bus.wdata),
    .rdata     (bus.rdata),
    .sel       (bus.sel),
    .out_data  (bus.out_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .in_data   (bus.in_data),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       ovf;
  logic       unf;

  logic [31:0] rd;
  logic [7:0]  od;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s        = 32'h0;
    s[0]     = (rx_q.size() != 0);
    s[1]     = (tx_q.size() == DEPTH);
    s[2]     = ovf;
    s[3]     = unf;
    s[7:4]   = 4'(rx_q.size());
    s[11:8]  = 4'(tx_q.size());
    return s;
  endfunction

  task automatic drive(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] wd, input logic ordy,
                       input logic ivld, input logic [7:0] id);
    bus.we = w; bus.re = r; bus.addr = a; bus.wdata = wd;
    bus.out_ready = ordy; bus.in_valid = ivld; bus.in_data = id;
  endtask

  // One bus cycle: drive, compare outputs with the model, clock, update model.
  task automatic cycle(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] wd, input logic ordy,
                       input logic ivld, input logic [7:0] id,
                       output logic [31:0] rd_obs, output logic [7:0] od_obs);
    bit is_data, is_stat, tx_pop, tx_acc, rx_pop, rx_push;
    logic [31:0] exp_rd;
    drive(w, r, a, wd, ordy, ivld, id);
    #1;
    is_data = (a == BASE);
    is_stat = (a == BASE + 32'd4);
    exp_rd  = is_data ? ((rx_q.size() != 0) ? {24'h0, rx_q[0]} : 32'h0)
            : is_stat ? model_status() : 32'h0;
    check("sel", {31'h0, bus.sel}, {31'h0, is_data | is_stat});
    if (r && !w) check("rdata", bus.rdata, exp_rd);
    check("out_valid", {31'h0, bus.out_valid}, {31'h0, tx_q.size() != 0});
    if (tx_q.size() != 0) check("out_data", {24'h0, bus.out_data}, {24'h0, tx_q[0]});
    check("in_ready", {31'h0, bus.in_ready}, {31'h0, rx_q.size() < DEPTH});
    rd_obs = bus.rdata;
    od_obs = bus.out_data;

    tx_pop  = (tx_q.size() != 0) && ordy;
    tx_acc  = w && is_data && ((tx_q.size() < DEPTH) || tx_pop);
    rx_pop  = r && !w && is_data && (rx_q.size() != 0);
    rx_push = ivld && (rx_q.size() < DEPTH);

    @(posedge clk);
    if (w && is_data && !tx_acc)               ovf = 1'b1;
    if (r && !w && is_data && rx_q.size() == 0) unf = 1'b1;
    if (w && is_stat && wd[2])                 ovf = 1'b0;
    if (w && is_stat && wd[3])                 unf = 1'b0;
    if (tx_pop)  void'(tx_q.pop_front());
    if (tx_acc)  tx_q.push_back(wd[7:0]);
    if (rx_pop)  void'(rx_q.pop_front());
    if (rx_push) rx_q.push_back(id);
    #1;
  endtask

  // Look at a register without clocking.
  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, 1'b1, a, 32'h0, 1'b0, 1'b0, 8'h0);
    #1;
    check(tag, bus.rdata, exp);
  endtask

  // Asynchronous reset entered between edges; outputs must clear at once.
  task automatic do_reset();
    drive(1'b0, 1'b1, BASE + 32'd4, 32'h0, 1'b0, 1'b0, 8'h0);
    reset = 1'b1;
    tx_q.delete();
    rx_q.delete();
    ovf = 1'b0;
    unf = 1'b0;
    #1;
    check("rst out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rst in_ready",  {31'h0, bus.in_ready},  32'h1);
    check("rst status",    bus.rdata,              32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [7:0] exp_drain [4];

  initial begin
    ovf = 1'b0;
    unf = 1'b0;
    drive(1'b0, 1'b0, BASE + 32'd4, 32'h0, 1'b0, 1'b0, 8'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Single store shows up on the TX stream right after its edge.
    cycle(1, 0, BASE, 32'hA5, 0, 0, 8'h0, rd, od);
    #1;
    check("a5 out_valid", {31'h0, bus.out_valid}, 32'h1);
    check("a5 out_data",  {24'h0, bus.out_data},  32'hA5);
    peek("a5 status", BASE + 32'd4, 32'h0000_0100);

    // Five stores into a stalled TX: fifth is dropped and flagged.
    do_reset();
    for (int i = 1; i <= 5; i++)
      cycle(1, 0, BASE, 32'(i), 0, 0, 8'h0, rd, od);
    peek("ovf status", BASE + 32'd4, 32'h0000_0406);
    check("ovf head", {24'h0, bus.out_data}, 32'h01);

    // Clear TX_OVF, then store into full TX while the head drains.
    cycle(1, 0, BASE + 32'd4, 32'h4, 0, 0, 8'h0, rd, od);
    peek("w1c ovf", BASE + 32'd4, 32'h0000_0402);
    cycle(1, 0, BASE, 32'h55, 1, 0, 8'h0, rd, od);
    peek("full+pop status", BASE + 32'd4, 32'h0000_0402);
    exp_drain = '{8'h02, 8'h03, 8'h04, 8'h55};
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, BASE + 32'd8, 32'h0, 1, 0, 8'h0, rd, od);
      check("drain order", {24'h0, od}, {24'h0, exp_drain[i]});
    end
    peek("drained status", BASE + 32'd4, 32'h0);

    // RX path: two bytes in, two loads out in order.
    cycle(0, 0, BASE + 32'd8, 32'h0, 0, 1, 8'h3C, rd, od);
    cycle(0, 0, BASE + 32'd8, 32'h0, 0, 1, 8'h7E, rd, od);
    cycle(0, 1, BASE, 32'h0, 0, 0, 8'h0, rd, od);
    check("rx first",  rd, 32'h3C);
    cycle(0, 1, BASE, 32'h0, 0, 0, 8'h0, rd, od);
    check("rx second", rd, 32'h7E);
    peek("rx empty status", BASE + 32'd4, 32'h0);

    // Underflow, then write-1-to-clear.
    cycle(0, 1, BASE, 32'h0, 0, 0, 8'h0, rd, od);
    check("unf rdata", rd, 32'h0);
    peek("unf status", BASE + 32'd4, 32'h0000_0008);
    cycle(1, 0, BASE + 32'd4, 32'h8, 0, 0, 8'h0, rd, od);
    peek("w1c unf", BASE + 32'd4, 32'h0);

    // Load of empty RX with a same-cycle push: no forwarding.
    cycle(0, 1, BASE, 32'h0, 0, 1, 8'h99, rd, od);
    check("no fwd rdata", rd, 32'h0);
    peek("no fwd status", BASE + 32'd4, 32'h0000_0019);
    // Store and load together: store wins, RX keeps its byte.
    cycle(1, 1, BASE, 32'h77, 0, 0, 8'h0, rd, od);
    peek("we+re status", BASE + 32'd4, 32'h0000_0119);
    cycle(1, 0, BASE + 32'd4, 32'hC, 1, 0, 8'h0, rd, od);
    cycle(0, 1, BASE, 32'h0, 0, 0, 8'h0, rd, od);
    check("rx 99", rd, 32'h99);

    // Reset with bytes queued in TX.
    for (int i = 0; i < 3; i++)
      cycle(1, 0, BASE, 32'(8'hE0 + i), 0, 0, 8'h0, rd, od);
    check("pre-rst out_valid", {31'h0, bus.out_valid}, 32'h1);
    do_reset();
    peek("unmapped rdata", BASE + 32'd8, 32'h0);
    check("unmapped sel", {31'h0, bus.sel}, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      int pick;
      pick = $urandom_range(0, 7);
      case (pick)
        0, 1, 2: a = BASE;
        3, 4:    a = BASE + 32'd4;
        5:       a = BASE + 32'd8;
        6:       a = BASE - 32'd4;
        default: a = $urandom;
      endcase
      cycle(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 4), a, $urandom,
            $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom), rd, od);
    end
    peek("final status", BASE + 32'd4, model_status());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_fifo_port.md
MMIO_FIFO_PORT -- requirements
Module: mmio_fifo_port

Interface
REQ-001 SHALL have parameter BASE, default 32'h800, byte address of the DATA register.
REQ-002 SHALL have parameter DEPTH, default 4, entries per FIFO (power of two, >=2).
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port addr  input  32  CPU byte address (ALUResult).
REQ-006 SHALL have port we  input  1  CPU store strobe (MemWrite).
REQ-007 SHALL have port re  input  1  CPU load strobe (MemtoReg).
REQ-008 SHALL have port wdata  input  32  CPU store data.
REQ-009 SHALL have port rdata  output  32  CPU load data, combinational.
REQ-010 SHALL have port sel  output  1  high when addr equals BASE or BASE+4; steers the CPU read mux.
REQ-011 SHALL have ports out_data  output  8, out_valid  output  1, out_ready  input  1  external TX stream.
REQ-012 SHALL have ports in_data  input  8, in_valid  input  1, in_ready  output  1  external RX stream.

Function
REQ-013 SHALL contain a TX FIFO (CPU to external) and an RX FIFO (external to CPU), each DEPTH x 8 bits.
REQ-014 SHALL decode DATA at BASE; store pushes wdata[7:0] into TX.
REQ-015 SHALL return {24'b0, RX head} on a DATA load; re at DATA pops RX at the clock edge.
REQ-016 SHALL decode STATUS at BASE+4.
REQ-017 STATUS read layout SHALL be: bit0 RX_NOT_EMPTY, bit1 TX_FULL, bit2 TX_OVF, bit3 RX_UNF, bits[7:4] RX count, bits[11:8] TX count, other bits 0.
REQ-018 A STATUS store SHALL clear TX_OVF where wdata[2]=1 and RX_UNF where wdata[3]=1 (write-1-to-clear); other bits are ignored.
REQ-019 SHALL drive rdata=0 and sel=0 for any address other than DATA and STATUS, with no side effects.
REQ-020 A DATA load with RX empty SHALL return 0, not pop, and set sticky RX_UNF.
REQ-021 A DATA store with TX full and no same-cycle TX pop SHALL drop the byte and set sticky TX_OVF.
REQ-022 A DATA store with TX full SHALL be accepted if the same cycle also has out_valid & out_ready.
REQ-023 SHALL drive out_valid = TX not empty and out_data = TX head; the head pops when out_valid & out_ready.
REQ-024 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 SHALL drive in_ready = RX not full, from registered state only (no bypass from a same-cycle CPU pop).
REQ-026 SHALL push in_data into RX when in_valid & in_ready.
REQ-027 If RX is empty, a same-cycle RX push SHALL NOT be forwarded to rdata.
REQ-028 Simultaneous push and pop on the same FIFO SHALL leave its count unchanged and preserve order.
REQ-029 Read/write pointers SHALL wrap modulo DEPTH; counts SHALL range 0..DEPTH.
REQ-030 If we and re are both asserted, the store SHALL take effect and the load SHALL be ignored.
REQ-031 Latency: a byte stored at edge N SHALL appear on out_data with out_valid=1 after edge N; an RX byte pushed at edge N SHALL be readable in the cycle after edge N.

Reset
REQ-032 reset SHALL asynchronously empty both FIFOs (pointers and counts 0) and clear TX_OVF and RX_UNF.
REQ-033 During and after reset, outputs SHALL be: out_valid=0, in_ready=1, STATUS reads 0; FIFO storage contents are don't-care.
REQ-034 reset asserted mid-transfer SHALL discard all queued bytes; no partial state survives.

Structure
REQ-035 Package mmio_pkg SHALL hold the DATA/STATUS offsets (0, 4) and STATUS bit-position constants, shared with firmware tests.
REQ-036 SHALL instantiate one sub-module, sync_fifo (parameters WIDTH and DEPTH; signals push, pop, din, dout, full, empty, count), twice.

Verification
REQ-037 Reset, then store 8'hA5 to 0x800 with out_ready=0 -> out_valid=1, out_data=A5; STATUS=0x00000100.
REQ-038 Store 5 bytes 01..05 with out_ready=0 -> bytes 01..04 queued; STATUS bit1=1, bit2=1; TX count=4.
REQ-039 Send in_data 3C then 7E via in_valid, then two loads from 0x800 -> rdata 0x3C then 0x7E; STATUS bit0=0 afterwards.
REQ-040 Load 0x800 with RX empty -> rdata=0, RX_UNF=1; store 0x8 to 0x804 -> RX_UNF=0.
REQ-041 TX full, then a store of 8'h55 in the same cycle as out_ready=1 -> store accepted, no TX_OVF, TX count remains 4; 55 emerges last.
REQ-042 Assert reset with 3 bytes in TX -> out_valid=0 immediately, without a clock edge; load from 0x808 -> rdata=0, sel=0.
